// File: rtl/instruction_cache.sv
// instruction_cache
// Direct-mapped, one-word-per-line instruction cache in front of the fetcher.
// A hit answers one cycle after the request. A miss refills one word through
// a level mc_req / pulse mc_done handshake and answers on the refill edge.
// clear abandons any outstanding fetch without touching the arrays.
// Optional feature macro: ICACHE_STAT_EN adds saturating hit/miss counters.
module instruction_cache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        ins_asked,
  input  logic [31:0] ins_addr,
  output logic        ic_rdy,
  output logic [31:0] ins,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_data
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    MISS,
    RESP
  } state_t;

  state_t state;

  logic [LINES-1:0]    valid_bits;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  lookup_hit;
  logic                  fill_fire;
  logic                  unused_addr_bits;

  // Byte offset bits of the fetch address carry no information for a word cache
  assign unused_addr_bits = ^ins_addr[1:0];

  // Split the incoming request and the latched refill address into index and tag
  assign req_index  = ins_addr[INDEX_BITS+1:2];
  assign req_tag    = ins_addr[31:INDEX_BITS+2];
  assign fill_index = mc_addr[INDEX_BITS+1:2];
  assign fill_tag   = mc_addr[31:INDEX_BITS+2];

  assign lookup_hit = valid_bits[req_index] && (tag_mem[req_index] == req_tag);

  // A refill lands only when it is accepted by the FSM: not frozen, not reset, not cleared
  assign fill_fire = rst && rdy && !clear && (state == MISS) && mc_done;

  // Tag and data arrays carry no reset; the valid bits alone decide whether a line is usable
  always_ff @(posedge clk) begin
    if (fill_fire) begin
      tag_mem[fill_index]  <= fill_tag;
      data_mem[fill_index] <= mc_data;
    end
  end

  // Control FSM with registered outputs and the valid bit array
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      valid_bits <= '0;
      ic_rdy     <= 1'b0;
      ins        <= '0;
      mc_req     <= 1'b0;
      mc_addr    <= '0;
    end else if (rdy) begin
      ic_rdy <= 1'b0;
      if (clear) begin
        state  <= IDLE;
        mc_req <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ins_asked) begin
              if (lookup_hit) begin
                ic_rdy <= 1'b1;
                ins    <= data_mem[req_index];
              end else begin
                mc_req  <= 1'b1;
                mc_addr <= {ins_addr[31:2], 2'b00};
                state   <= MISS;
              end
            end
          end
          MISS: begin
            if (mc_done) begin
              valid_bits[fill_index] <= 1'b1;
              ins    <= mc_data;
              ic_rdy <= 1'b1;
              mc_req <= 1'b0;
              state  <= RESP;
            end
          end
          RESP: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef ICACHE_STAT_EN
  logic hit_served;
  logic miss_started;

  assign hit_served   = rst && rdy && !clear && (state == IDLE) && ins_asked && lookup_hit;
  assign miss_started = rst && rdy && !clear && (state == IDLE) && ins_asked && !lookup_hit;

  // Saturating event counters; misses are counted when they start, even if later aborted
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_served && (hit_cnt != 32'hFFFF_FFFF)) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (miss_started && (miss_cnt != 32'hFFFF_FFFF)) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// tb_instruction_cache
// Directed bench for instruction_cache with a behavioural reference model.
// Inputs change 1 time unit after each rising edge; the model predicts the
// outputs for the next edge on the falling edge and compares the previous
// prediction against the DUT at the same time.
module tb_instruction_cache;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic        ins_asked;
  logic [31:0] ins_addr;
  logic        ic_rdy;
  logic [31:0] ins;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_done;
  logic [31:0] mc_data;
`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: one stored word address per line index
  logic [31:0] m_line_addr [int];
  logic [31:0] m_line_data [int];
  bit          known    = 1'b0;
  bit          pending  = 1'b0;
  bit          gap      = 1'b0;
  logic [31:0] pend_addr = '0;
  logic        exp_ic   = 1'b0;
  logic [31:0] exp_ins  = '0;
  logic        exp_req  = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_hits = '0;
  logic [31:0] exp_miss = '0;

  instruction_cache #(.INDEX_BITS(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .clear    (clear),
    .ins_asked(ins_asked),
    .ins_addr (ins_addr),
    .ic_rdy   (ic_rdy),
    .ins      (ins),
    .mc_req   (mc_req),
    .mc_addr  (mc_addr),
    .mc_done  (mc_done),
    .mc_data  (mc_data)
`ifdef ICACHE_STAT_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the edge that sampled them
  task automatic applyStimulus(input logic a_rst, input logic a_rdy, input logic a_clear,
                               input logic a_asked, input logic [31:0] a_addr,
                               input logic a_done, input logic [31:0] a_data);
    rst       = a_rst;
    rdy       = a_rdy;
    clear     = a_clear;
    ins_asked = a_asked;
    ins_addr  = a_addr;
    mc_done   = a_done;
    mc_data   = a_data;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic request(input logic [31:0] a);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, a, 1'b0, 32'h0);
  endtask

  task automatic refill(input logic [31:0] d);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, d);
  endtask

  // Request a word; if it misses, return the data after lat cycles of memory latency
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int lat);
    request(a);
    if (mc_req) begin
      for (int k = 0; k < lat; k++) idleCycle();
      refill(d);
    end
    idleCycle();
  endtask

  // Model: compare the last prediction, then predict the outcome of the next edge
  initial begin : model_and_compare
    int idx;
    forever begin
      @(negedge clk);
      if (known) begin
        checkOutput("ic_rdy", {31'b0, ic_rdy}, {31'b0, exp_ic});
        checkOutput("mc_req", {31'b0, mc_req}, {31'b0, exp_req});
        checkOutput("mc_addr", mc_addr, exp_addr);
        if (exp_ic) checkOutput("ins", ins, exp_ins);
`ifdef ICACHE_STAT_EN
        checkOutput("hit_cnt", hit_cnt, exp_hits);
        checkOutput("miss_cnt", miss_cnt, exp_miss);
`endif
      end
      if (!rst) begin
        known    = 1'b1;
        pending  = 1'b0;
        gap      = 1'b0;
        exp_ic   = 1'b0;
        exp_ins  = '0;
        exp_req  = 1'b0;
        exp_addr = '0;
        exp_hits = '0;
        exp_miss = '0;
        m_line_addr.delete();
        m_line_data.delete();
      end else if (rdy) begin
        exp_ic = 1'b0;
        if (clear) begin
          pending = 1'b0;
          gap     = 1'b0;
          exp_req = 1'b0;
        end else if (pending) begin
          if (mc_done) begin
            idx = int'((pend_addr / 4) % 64);
            m_line_addr[idx] = pend_addr;
            m_line_data[idx] = mc_data;
            exp_ins = mc_data;
            exp_ic  = 1'b1;
            exp_req = 1'b0;
            pending = 1'b0;
            gap     = 1'b1;
          end
        end else if (gap) begin
          gap = 1'b0;
        end else if (ins_asked) begin
          idx = int'((ins_addr / 4) % 64);
          if (m_line_addr.exists(idx) && (m_line_addr[idx] == (ins_addr & 32'hFFFF_FFFC))) begin
            exp_ic  = 1'b1;
            exp_ins = m_line_data[idx];
            if (exp_hits != 32'hFFFF_FFFF) exp_hits = exp_hits + 1;
          end else begin
            pending   = 1'b1;
            pend_addr = ins_addr & 32'hFFFF_FFFC;
            exp_req   = 1'b1;
            exp_addr  = pend_addr;
            if (exp_miss != 32'hFFFF_FFFF) exp_miss = exp_miss + 1;
          end
        end
      end
    end
  end

  // Directed scenarios with hand-computed literal expectations
  initial begin : stimulus
    logic [31:0] table_addr [10];
    int          table_lat  [10];
    table_addr = '{32'h04, 32'h08, 32'h04, 32'h104, 32'h04, 32'hFC,
                   32'hFFFF_FFFC, 32'hFC, 32'h0FF8, 32'h08};
    table_lat  = '{0, 2, 0, 1, 0, 3, 0, 1, 2, 0};

    // Reset
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("lit_reset_ic_rdy", {31'b0, ic_rdy}, 32'h0);
    checkOutput("lit_reset_mc_req", {31'b0, mc_req}, 32'h0);
    checkOutput("lit_reset_mc_addr", mc_addr, 32'h0);
    checkOutput("lit_reset_ins", ins, 32'h0);

    // Cold miss on 0x0
    request(32'h0);
    checkOutput("lit_cold_mc_req", {31'b0, mc_req}, 32'h1);
    checkOutput("lit_cold_mc_addr", mc_addr, 32'h0);
    idleCycle();
    idleCycle();
    checkOutput("lit_cold_req_held", {31'b0, mc_req}, 32'h1);
    refill(32'h0000_0013);
    checkOutput("lit_cold_ic_rdy", {31'b0, ic_rdy}, 32'h1);
    checkOutput("lit_cold_ins", ins, 32'h0000_0013);
    checkOutput("lit_model_cold_ins", exp_ins, 32'h0000_0013);
    idleCycle();
    checkOutput("lit_cold_pulse_end", {31'b0, ic_rdy}, 32'h0);

    // Hits, back to back, byte offset ignored
    request(32'h0);
    checkOutput("lit_hit_ic_rdy", {31'b0, ic_rdy}, 32'h1);
    checkOutput("lit_hit_ins", ins, 32'h0000_0013);
    request(32'h3);
    checkOutput("lit_hit3_ic_rdy", {31'b0, ic_rdy}, 32'h1);
    checkOutput("lit_hit3_mc_req", {31'b0, mc_req}, 32'h0);
    idleCycle();

    // Conflict on index 0
    request(32'h100);
    checkOutput("lit_conf_mc_addr", mc_addr, 32'h100);
    refill(32'h1111_0100);
    idleCycle();
    request(32'h0);
    checkOutput("lit_conf_remiss", {31'b0, mc_req}, 32'h1);
    refill(32'h0000_0013);
    idleCycle();
`ifdef ICACHE_STAT_EN
    checkOutput("lit_stat_hits", hit_cnt, 32'd2);
    checkOutput("lit_stat_misses", miss_cnt, 32'd3);
`endif

    // Clear mid-miss, late mc_done is discarded
    request(32'h200);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("lit_clear_mc_req", {31'b0, mc_req}, 32'h0);
    refill(32'hDEAD_BEEF);
    checkOutput("lit_clear_no_rdy", {31'b0, ic_rdy}, 32'h0);
    idleCycle();
    request(32'h200);
    checkOutput("lit_clear_remiss", {31'b0, mc_req}, 32'h1);
    // Clear on the same cycle as mc_done
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    checkOutput("lit_clrdone_no_rdy", {31'b0, ic_rdy}, 32'h0);
    idleCycle();
    request(32'h200);
    checkOutput("lit_clrdone_remiss", mc_addr, 32'h200);
    refill(32'hABCD_0200);
    idleCycle();
    // Clear wins over a same-cycle request that would hit
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    checkOutput("lit_clear_drop_req", {31'b0, ic_rdy}, 32'h0);
    idleCycle();
    // A pending ic_rdy pulse is held while frozen
    request(32'h200);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("lit_freeze_pulse", {31'b0, ic_rdy}, 32'h1);
    checkOutput("lit_freeze_ins", ins, 32'hABCD_0200);
    idleCycle();

    // Freeze during a miss, then reset while frozen
    request(32'h44);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("lit_freeze_req", {31'b0, mc_req}, 32'h1);
    checkOutput("lit_freeze_addr", mc_addr, 32'h44);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("lit_rst_mid_miss", {31'b0, mc_req}, 32'h0);
    request(32'h0);
    checkOutput("lit_rst_invalidated", {31'b0, mc_req}, 32'h1);
    refill(32'h0000_0013);
    idleCycle();
    fetch(32'h200, 32'h2222_0200, 1);

    // Table of mixed hits, misses and conflicts, including index 63 and tag boundaries
    for (int i = 0; i < 10; i++) fetch(table_addr[i], table_addr[i] ^ 32'hA5A5_0000, table_lat[i]);
    idleCycle();
    idleCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
